// File: rtl/demux_destino_pkg.sv
// Shared constants and types for the destination demux that sits after the VC pop logic.
package demux_destino_pkg;

    localparam int unsigned DATA_WIDTH = 6;
    localparam int unsigned DEST_BIT   = 4;
    localparam int unsigned SKID_DEPTH = 4;
    localparam int unsigned CNT_WIDTH  = 8;
    localparam int unsigned SKID_PTR_W = $clog2(SKID_DEPTH);

    typedef enum logic {
        DEST_D0 = 1'b0,
        DEST_D1 = 1'b1
    } dest_e;

endpackage

// File: rtl/demux_destino_skid_destino.sv
// Per-destination skid buffer: circular queue with one write port and one pop port.
module skid_destino #(
    parameter int unsigned Width = demux_destino_pkg::DATA_WIDTH,
    parameter int unsigned Depth = demux_destino_pkg::SKID_DEPTH,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = $clog2(Depth + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en_i,
    input  logic [Width-1:0] wr_data_i,
    input  logic             pop_i,
    output logic [Width-1:0] head_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CntW-1:0]  count_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             wr_ok;
    logic             rd_ok;

    // A full buffer refuses the write even when it pops in the same cycle.
    assign wr_ok   = wr_en_i && !full_o;
    assign rd_ok   = pop_i && !empty_o;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(Depth));
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (rd_ok) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_q + CntW'(wr_ok) - CntW'(rd_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule

// File: rtl/demux_destino.sv
// Routes one VC word per cycle by its destination bit into per-destination skids,
// draining each skid into FIFO D0/D1 with registered push strobes.
module demux_destino #(
    parameter int unsigned DATA_WIDTH = demux_destino_pkg::DATA_WIDTH,
    parameter int unsigned DEST_BIT   = demux_destino_pkg::DEST_BIT,
    parameter int unsigned SKID_DEPTH = demux_destino_pkg::SKID_DEPTH,
    parameter int unsigned CNT_WIDTH  = demux_destino_pkg::CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pop_delay_VC0,
    input  logic                  pop_delay_VC1,
    input  logic [DATA_WIDTH-1:0] data_arbitro_VC0,
    input  logic [DATA_WIDTH-1:0] data_arbitro_VC1,
    input  logic                  full_fifo_D0,
    input  logic                  full_fifo_D1,
    output logic                  push_D0,
    output logic                  push_D1,
    output logic [DATA_WIDTH-1:0] data_out_D0,
    output logic [DATA_WIDTH-1:0] data_out_D1,
    output logic                  overflow_err,
    output logic [CNT_WIDTH-1:0]  cnt_push_D0,
    output logic [CNT_WIDTH-1:0]  cnt_push_D1,
    output logic                  idle
);
    import demux_destino_pkg::*;

    localparam int unsigned SkidCntW = $clog2(SKID_DEPTH + 1);

    logic                  park_valid_q, park_valid_d;
    logic [DATA_WIDTH-1:0] park_data_q, park_data_d;
    logic                  wr_valid;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  sel_drop;
    dest_e                 wr_dest;

    logic                  wr_d0, wr_d1;
    logic                  acc_d0, acc_d1;
    logic                  route_drop;
    logic                  pop_d0, pop_d1;
    logic [DATA_WIDTH-1:0] head_d0, head_d1;
    logic                  empty_d0, empty_d1;
    logic                  full_d0, full_d1;
    logic [SkidCntW-1:0]   occ_d0, occ_d1;
    logic [SkidCntW-1:0]   occ_nxt_d0, occ_nxt_d1;

    logic                  push_d0_q, push_d1_q;
    logic [DATA_WIDTH-1:0] data_d0_q, data_d1_q;
    logic [CNT_WIDTH-1:0]  cnt_d0_q, cnt_d1_q;
    logic                  overflow_q;
    logic                  idle_q, idle_d;

    // Priority park > VC0 > VC1; the park register absorbs the loser of a collision.
    always_comb begin
        park_valid_d = 1'b0;
        park_data_d  = park_data_q;
        wr_valid     = 1'b0;
        wr_data      = park_data_q;
        sel_drop     = 1'b0;
        if (park_valid_q) begin
            wr_valid = 1'b1;
            if (pop_delay_VC0) begin
                park_valid_d = 1'b1;
                park_data_d  = data_arbitro_VC0;
                sel_drop     = pop_delay_VC1;
            end else if (pop_delay_VC1) begin
                park_valid_d = 1'b1;
                park_data_d  = data_arbitro_VC1;
            end
        end else if (pop_delay_VC0) begin
            wr_valid = 1'b1;
            wr_data  = data_arbitro_VC0;
            if (pop_delay_VC1) begin
                park_valid_d = 1'b1;
                park_data_d  = data_arbitro_VC1;
            end
        end else if (pop_delay_VC1) begin
            wr_valid = 1'b1;
            wr_data  = data_arbitro_VC1;
        end
    end

    assign wr_dest    = dest_e'(wr_data[DEST_BIT]);
    assign wr_d0      = wr_valid && (wr_dest == DEST_D0);
    assign wr_d1      = wr_valid && (wr_dest == DEST_D1);
    assign acc_d0     = wr_d0 && !full_d0;
    assign acc_d1     = wr_d1 && !full_d1;
    assign route_drop = (wr_d0 && full_d0) || (wr_d1 && full_d1);

    assign pop_d0 = !empty_d0 && !full_fifo_D0;
    assign pop_d1 = !empty_d1 && !full_fifo_D1;

    skid_destino #(
        .Width (DATA_WIDTH),
        .Depth (SKID_DEPTH)
    ) u_skid_d0 (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (wr_d0),
        .wr_data_i (wr_data),
        .pop_i     (pop_d0),
        .head_o    (head_d0),
        .empty_o   (empty_d0),
        .full_o    (full_d0),
        .count_o   (occ_d0)
    );

    skid_destino #(
        .Width (DATA_WIDTH),
        .Depth (SKID_DEPTH)
    ) u_skid_d1 (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (wr_d1),
        .wr_data_i (wr_data),
        .pop_i     (pop_d1),
        .head_o    (head_d1),
        .empty_o   (empty_d1),
        .full_o    (full_d1),
        .count_o   (occ_d1)
    );

    // idle is registered from the post-edge state so it drops as soon as a word lands.
    assign occ_nxt_d0 = occ_d0 + SkidCntW'(acc_d0) - SkidCntW'(pop_d0);
    assign occ_nxt_d1 = occ_d1 + SkidCntW'(acc_d1) - SkidCntW'(pop_d1);
    assign idle_d     = !park_valid_d && (occ_nxt_d0 == '0) && (occ_nxt_d1 == '0) &&
                        !pop_d0 && !pop_d1;

    always_ff @(posedge clk) begin
        if (reset) begin
            park_valid_q <= 1'b0;
            park_data_q  <= '0;
            push_d0_q    <= 1'b0;
            push_d1_q    <= 1'b0;
            data_d0_q    <= '0;
            data_d1_q    <= '0;
            cnt_d0_q     <= '0;
            cnt_d1_q     <= '0;
            overflow_q   <= 1'b0;
            idle_q       <= 1'b1;
        end else begin
            park_valid_q <= park_valid_d;
            park_data_q  <= park_data_d;
            push_d0_q    <= pop_d0;
            push_d1_q    <= pop_d1;
            if (pop_d0) begin
                data_d0_q <= head_d0;
            end
            if (pop_d1) begin
                data_d1_q <= head_d1;
            end
            cnt_d0_q     <= cnt_d0_q + CNT_WIDTH'(pop_d0);
            cnt_d1_q     <= cnt_d1_q + CNT_WIDTH'(pop_d1);
            overflow_q   <= overflow_q || sel_drop || route_drop;
            idle_q       <= idle_d;
        end
    end

    assign push_D0      = push_d0_q;
    assign push_D1      = push_d1_q;
    assign data_out_D0  = data_d0_q;
    assign data_out_D1  = data_d1_q;
    assign cnt_push_D0  = cnt_d0_q;
    assign cnt_push_D1  = cnt_d1_q;
    assign overflow_err = overflow_q;
    assign idle         = idle_q;

endmodule
